// File: rtl/lock_pkg.sv
// lock_pkg
//   Shared types and constants for the combination-lock sequencer.
//   state_t      : supervisory FSM states
//   disp_mode_t  : display mode codes consumed by the HEX driver
//   MAX_DIGIT    : largest legal decimal digit on the switches
//   disp_for()   : maps a state (plus the digit-validity flag) to a display mode
package lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CLOSED  = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    DISP_DIGIT  = 3'd0,
    DISP_OPEN   = 3'd1,
    DISP_CLOSED = 3'd2,
    DISP_LOCKED = 3'd3,
    DISP_ERROR  = 3'd4
  } disp_mode_t;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // ENTRY shows the digit being keyed, or ERROR while the switches hold a
  // non-decimal value; every other state has a fixed display.
  function automatic disp_mode_t disp_for(state_t s, logic invalid_digit);
    disp_mode_t m;
    case (s)
      OPEN:    m = DISP_OPEN;
      CLOSED:  m = DISP_CLOSED;
      LOCKOUT: m = DISP_LOCKED;
      default: m = invalid_digit ? DISP_ERROR : DISP_DIGIT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// lock_sequencer_if
//   Bundles the user/datapath-facing signals of the lock sequencer.
//   enter, clear     : user buttons (levels)
//   digit_in         : switch value being committed
//   digit_match      : datapath compare result for digit_in vs code[digit_idx]
//   digit_idx        : code position currently compared
//   disp_mode        : display mode for the HEX driver
//   tries_left       : remaining attempts
//   is_open          : lock is open
//   lockout_active   : lockout timer running
//   modport master   : user/datapath side
//   modport slave    : sequencer side
interface lock_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             enter;
  logic             clear;
  logic [3:0]       digit_in;
  logic             digit_match;
  logic [IDX_W-1:0] digit_idx;
  logic [2:0]       disp_mode;
  logic [2:0]       tries_left;
  logic             is_open;
  logic             lockout_active;

  modport master (
    output enter, clear, digit_in, digit_match,
    input  digit_idx, disp_mode, tries_left, is_open, lockout_active
  );

  modport slave (
    input  enter, clear, digit_in, digit_match,
    output digit_idx, disp_mode, tries_left, is_open, lockout_active
  );
endinterface

// File: rtl/lockout_timer.sv
// lockout_timer
//   Loadable down-counter. load puts CYCLES-1 into the counter; it then
//   decrements once per clock and parks at zero. done is high while the
//   count is zero, so a state that waits for done after loading dwells
//   exactly CYCLES clocks.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : reload request (wins over decrement)
//   done       : count has reached zero
module lockout_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Supervisory FSM for the combination lock. Steps digit_idx through the
//   code while an external datapath reports digit_match, counts failed
//   attempts, imposes a timed lockout after MAX_TRIES failures and selects
//   the display mode. All outputs are registered (Moore).
//   clk    : system clock
//   rst_n  : async active-low reset
//   bus    : lock_sequencer_if.slave (enter, clear, digit_in, digit_match in;
//            digit_idx, disp_mode, tries_left, is_open, lockout_active out)
//   Parameters: CODE_LEN, MAX_TRIES (1..7), LOCKOUT_CYCLES (>=1), IDX_W.
//   Optional: define LOCK_INACTIVITY_TIMEOUT_EN to add an idle timeout
//   (parameter INACT_CYCLES) that abandons a partial entry without
//   consuming a try.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ENTRY   | collecting digits; digit_idx is the position being compared
//   CLOSED  | attempt failed, tries remain; next commit resumes entry
//   OPEN    | correct code entered; clear relocks
//   LOCKOUT | out of tries; timer running, commit/clear ignored
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = 6,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int IDX_W          = $clog2(CODE_LEN)
`ifdef LOCK_INACTIVITY_TIMEOUT_EN
  ,
  parameter int INACT_CYCLES   = 250000000
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  lock_sequencer_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
  localparam logic [2:0]       TRIES_INIT = 3'(MAX_TRIES);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             bad_q;
  logic [2:0]       tries_q;
  disp_mode_t       disp_q;
  logic             is_open_q;
  logic             lockout_q;
  logic             enter_q;

  logic             commit;
  logic             digit_bad;
  logic             last_digit;
  logic             attempt_ok;
  logic [2:0]       tries_dec;
  logic             lock_load;
  logic             lock_done;

  // enter_q resets high so a button held through reset release is not a commit.
  assign commit     = bus.enter & ~enter_q;
  assign digit_bad  = (bus.digit_in > MAX_DIGIT) | ~bus.digit_match;
  assign last_digit = (idx_q == LAST_IDX);
  assign attempt_ok = ~bad_q & ~digit_bad;
  assign tries_dec  = (tries_q != 3'd0) ? tries_q - 3'd1 : 3'd0;

  always_comb begin
    state_nxt = state;
    lock_load = 1'b0;
    case (state)
      ENTRY: begin
        if (!bus.clear && commit && last_digit) begin
          if (attempt_ok) begin
            state_nxt = OPEN;
          end else if (tries_dec == 3'd0) begin
            state_nxt = LOCKOUT;
            lock_load = 1'b1;
          end else begin
            state_nxt = CLOSED;
          end
        end
      end
      CLOSED:  if (bus.clear || commit) state_nxt = ENTRY;
      OPEN:    if (bus.clear) state_nxt = ENTRY;
      LOCKOUT: if (lock_done) state_nxt = ENTRY;
      default: state_nxt = ENTRY;
    endcase
  end

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lock_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lock_load),
    .done  (lock_done)
  );

`ifdef LOCK_INACTIVITY_TIMEOUT_EN
  logic idle_load;
  logic idle_done;
  logic idle_abort;

  // Reloaded on each accepted digit and whenever ENTRY is (re)entered, so the
  // count always measures time since the most recent activity.
  assign idle_load  = ((state == ENTRY) && commit && !bus.clear) ||
                      ((state != ENTRY) && (state_nxt == ENTRY));
  assign idle_abort = (state == ENTRY) && (idx_q != '0) && idle_done;

  lockout_timer #(
    .CYCLES (INACT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (idle_load),
    .done  (idle_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ENTRY;
      idx_q     <= '0;
      bad_q     <= 1'b0;
      tries_q   <= TRIES_INIT;
      disp_q    <= DISP_DIGIT;
      is_open_q <= 1'b0;
      lockout_q <= 1'b0;
      enter_q   <= 1'b1;
    end else begin
      enter_q   <= bus.enter;
      state     <= state_nxt;
      disp_q    <= disp_for(state_nxt, bus.digit_in > MAX_DIGIT);
      is_open_q <= (state_nxt == OPEN);
      lockout_q <= (state_nxt == LOCKOUT);
      case (state)
        ENTRY: begin
          if (bus.clear) begin
            idx_q <= '0;
            bad_q <= 1'b0;
          end else if (commit) begin
            if (last_digit) begin
              idx_q <= '0;
              bad_q <= 1'b0;
              if (!attempt_ok) tries_q <= tries_dec;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              bad_q <= bad_q | digit_bad;
            end
          end
`ifdef LOCK_INACTIVITY_TIMEOUT_EN
          else if (idle_abort) begin
            idx_q <= '0;
            bad_q <= 1'b0;
          end
`endif
        end
        CLOSED: begin
          if (bus.clear || commit) begin
            idx_q <= '0;
            bad_q <= 1'b0;
          end
        end
        OPEN: begin
          if (bus.clear) tries_q <= TRIES_INIT;
        end
        LOCKOUT: begin
          if (lock_done) tries_q <= TRIES_INIT;
        end
        default: begin
          idx_q   <= '0;
          bad_q   <= 1'b0;
          tries_q <= TRIES_INIT;
        end
      endcase
    end
  end

  assign bus.digit_idx      = idx_q;
  assign bus.disp_mode      = disp_q;
  assign bus.tries_left     = tries_q;
  assign bus.is_open        = is_open_q;
  assign bus.lockout_active = lockout_q;
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer
//   Self-checking bench for lock_sequencer (CODE_LEN=6, MAX_TRIES=3,
//   LOCKOUT_CYCLES=20). The bench models the datapath (code 7-2-2-2-9-7) and
//   predicts outcomes per attempt from the collected digits.
module tb_lock_sequencer;
  localparam int CODE_LEN       = 6;
  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 20;
  localparam int IDX_W          = 3;

  localparam int D_DIGIT  = 0;
  localparam int D_OPEN   = 1;
  localparam int D_CLOSED = 2;
  localparam int D_LOCKED = 3;
  localparam int D_ERROR  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] code [0:7];

  lock_sequencer_if #(.IDX_W(IDX_W)) bus ();

  assign bus.digit_match = (bus.digit_in == code[bus.digit_idx]);

  lock_sequencer #(
    .CODE_LEN       (CODE_LEN),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .IDX_W          (IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    bus.digit_in = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One commit: rising enter at a negedge, returns at the following negedge
  // with enter low again (outputs already reflect the commit).
  task automatic commit(input logic [3:0] d);
    @(negedge clk);
    bus.digit_in = d;
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic wrong_attempt();
    commit(4'd7); commit(4'd2); commit(4'd2);
    commit(4'd2); commit(4'd9); commit(4'd1);
  endtask

  // Counts how many consecutive samples (one per clock) lockout_active stays
  // high, optionally poking enter/clear meanwhile.
  task automatic wait_lockout_end(input bit poke, output int n);
    n = 0;
    while (bus.lockout_active === 1'b1 && n < 200) begin
      n++;
      if (poke) begin
        bus.enter = 1'($urandom_range(0, 1));
        bus.clear = 1'($urandom_range(0, 1));
        bus.digit_in = 4'($urandom_range(0, 9));
      end
      @(posedge clk);
      #1;
    end
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    bus.digit_in = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.digit_idx, bus.disp_mode, bus.tries_left, bus.is_open, bus.lockout_active}
        !== {3'd0, 3'(D_DIGIT), 3'(MAX_TRIES), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: idx=%0d disp=%0d tries=%0d open=%0b lock=%0b expected 0/0/%0d/0/0",
               bus.digit_idx, bus.disp_mode, bus.tries_left, bus.is_open, bus.lockout_active, MAX_TRIES);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_open();
    do_reset();
    for (int i = 0; i < CODE_LEN; i++) begin
      checks++;
      if (bus.digit_idx !== 3'(i)) begin
        errors++;
        $display("FAIL open_idx_step: got %0d expected %0d", bus.digit_idx, i);
      end
      commit(code[i]);
    end
    checks++;
    if ({bus.is_open, bus.disp_mode, bus.digit_idx} !== {1'b1, 3'(D_OPEN), 3'd0}) begin
      errors++;
      $display("FAIL open_state: open=%0b disp=%0d idx=%0d expected 1/%0d/0",
               bus.is_open, bus.disp_mode, bus.digit_idx, D_OPEN);
    end
    commit(4'd3);
    checks++;
    if (bus.is_open !== 1'b1) begin
      errors++;
      $display("FAIL open_ignores_commit: open=%0b expected 1", bus.is_open);
    end
    pulse_clear();
    checks++;
    if ({bus.is_open, bus.disp_mode, bus.tries_left} !== {1'b0, 3'(D_DIGIT), 3'(MAX_TRIES)}) begin
      errors++;
      $display("FAIL open_clear: open=%0b disp=%0d tries=%0d expected 0/0/%0d",
               bus.is_open, bus.disp_mode, bus.tries_left, MAX_TRIES);
    end
  endtask

  task automatic test_closed();
    do_reset();
    commit(4'd7); commit(4'd3); commit(4'd2);
    commit(4'd2); commit(4'd9); commit(4'd7);
    checks++;
    if ({bus.disp_mode, bus.tries_left, bus.is_open} !== {3'(D_CLOSED), 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL closed_state: disp=%0d tries=%0d open=%0b expected %0d/2/0",
               bus.disp_mode, bus.tries_left, bus.is_open, D_CLOSED);
    end
    commit(4'd7);
    checks++;
    if ({bus.disp_mode, bus.digit_idx, bus.tries_left} !== {3'(D_DIGIT), 3'd0, 3'd2}) begin
      errors++;
      $display("FAIL closed_resume: disp=%0d idx=%0d tries=%0d expected 0/0/2",
               bus.disp_mode, bus.digit_idx, bus.tries_left);
    end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    for (int a = 0; a < MAX_TRIES; a++) begin
      wrong_attempt();
      if (a < MAX_TRIES - 1) commit(4'd0);
    end
    checks++;
    if ({bus.lockout_active, bus.disp_mode, bus.tries_left} !== {1'b1, 3'(D_LOCKED), 3'd0}) begin
      errors++;
      $display("FAIL lockout_enter: lock=%0b disp=%0d tries=%0d expected 1/%0d/0",
               bus.lockout_active, bus.disp_mode, bus.tries_left, D_LOCKED);
    end
    wait_lockout_end(1'b1, n);
    checks++;
    if (n != LOCKOUT_CYCLES) begin
      errors++;
      $display("FAIL lockout_dwell: got %0d cycles expected %0d", n, LOCKOUT_CYCLES);
    end
    checks++;
    if ({bus.lockout_active, bus.tries_left, bus.digit_idx, bus.disp_mode}
        !== {1'b0, 3'(MAX_TRIES), 3'd0, 3'(D_DIGIT)}) begin
      errors++;
      $display("FAIL lockout_exit: lock=%0b tries=%0d idx=%0d disp=%0d expected 0/%0d/0/0",
               bus.lockout_active, bus.tries_left, bus.digit_idx, bus.disp_mode, MAX_TRIES);
    end
  endtask

  task automatic test_error_digit();
    do_reset();
    bus.digit_in = 4'hB;
    @(negedge clk);
    checks++;
    if ({bus.disp_mode, bus.digit_idx} !== {3'(D_ERROR), 3'd0}) begin
      errors++;
      $display("FAIL error_display: disp=%0d idx=%0d expected %0d/0", bus.disp_mode, bus.digit_idx, D_ERROR);
    end
    commit(4'hB);
    checks++;
    if ({bus.disp_mode, bus.digit_idx} !== {3'(D_ERROR), 3'd1}) begin
      errors++;
      $display("FAIL error_commit: disp=%0d idx=%0d expected %0d/1", bus.disp_mode, bus.digit_idx, D_ERROR);
    end
    for (int i = 1; i < CODE_LEN; i++) commit(code[i]);
    checks++;
    if ({bus.disp_mode, bus.tries_left} !== {3'(D_CLOSED), 3'd2}) begin
      errors++;
      $display("FAIL error_attempt: disp=%0d tries=%0d expected %0d/2", bus.disp_mode, bus.tries_left, D_CLOSED);
    end
  endtask

  task automatic test_clear_commit();
    do_reset();
    commit(4'd7); commit(4'd2); commit(4'd2);
    checks++;
    if (bus.digit_idx !== 3'd3) begin
      errors++;
      $display("FAIL clr_pre_idx: got %0d expected 3", bus.digit_idx);
    end
    @(negedge clk);
    bus.clear = 1'b1;
    bus.enter = 1'b1;
    bus.digit_in = 4'd2;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.enter = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.digit_idx, bus.tries_left, bus.disp_mode} !== {3'd0, 3'(MAX_TRIES), 3'(D_DIGIT)}) begin
      errors++;
      $display("FAIL clr_and_commit: idx=%0d tries=%0d disp=%0d expected 0/%0d/0",
               bus.digit_idx, bus.tries_left, bus.disp_mode, MAX_TRIES);
    end
  endtask

  task automatic test_enter_held_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.enter = 1'b1;
    bus.digit_in = 4'd7;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.digit_idx !== 3'd0) begin
      errors++;
      $display("FAIL held_enter_reset: idx=%0d expected 0", bus.digit_idx);
    end
    bus.enter = 1'b0;
    commit(4'd7);
    checks++;
    if (bus.digit_idx !== 3'd1) begin
      errors++;
      $display("FAIL held_enter_then_commit: idx=%0d expected 1", bus.digit_idx);
    end
  endtask

  task automatic test_reset_mid_lockout();
    do_reset();
    for (int a = 0; a < MAX_TRIES; a++) begin
      wrong_attempt();
      if (a < MAX_TRIES - 1) commit(4'd0);
    end
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (bus.lockout_active !== 1'b1) begin
      errors++;
      $display("FAIL midlock_active: lock=%0b expected 1", bus.lockout_active);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.lockout_active, bus.tries_left, bus.digit_idx, bus.disp_mode}
        !== {1'b0, 3'(MAX_TRIES), 3'd0, 3'(D_DIGIT)}) begin
      errors++;
      $display("FAIL midlock_async_reset: lock=%0b tries=%0d idx=%0d disp=%0d expected 0/%0d/0/0",
               bus.lockout_active, bus.tries_left, bus.digit_idx, bus.disp_mode, MAX_TRIES);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Random attempts; the model only tracks remaining tries and judges each
  // attempt by comparing the collected digits against the code.
  task automatic test_random();
    int m_tries;
    int n;
    logic [3:0] digs [$];
    bit ok;
    do_reset();
    m_tries = MAX_TRIES;
    for (int a = 0; a < 30; a++) begin
      digs.delete();
      for (int i = 0; i < CODE_LEN; i++) begin
        logic [3:0] d;
        if ($urandom_range(0, 3) != 0) d = code[i];
        else d = 4'($urandom_range(0, 15));
        digs.push_back(d);
        commit(d);
        if (i < CODE_LEN - 1) begin
          checks++;
          if ({bus.digit_idx, bus.disp_mode} !== {3'(digs.size()), (d > 4'd9) ? 3'(D_ERROR) : 3'(D_DIGIT)}) begin
            errors++;
            $display("FAIL rand_step: idx=%0d disp=%0d expected idx %0d digit %0d",
                     bus.digit_idx, bus.disp_mode, digs.size(), d);
          end
        end
      end
      ok = 1'b1;
      for (int i = 0; i < CODE_LEN; i++) if (digs[i] != code[i]) ok = 1'b0;
      if (ok) begin
        checks++;
        if ({bus.is_open, bus.tries_left} !== {1'b1, 3'(m_tries)}) begin
          errors++;
          $display("FAIL rand_open: open=%0b tries=%0d expected 1/%0d", bus.is_open, bus.tries_left, m_tries);
        end
        pulse_clear();
        m_tries = MAX_TRIES;
      end else begin
        m_tries--;
        if (m_tries == 0) begin
          checks++;
          if ({bus.lockout_active, bus.tries_left} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL rand_lockout: lock=%0b tries=%0d expected 1/0", bus.lockout_active, bus.tries_left);
          end
          wait_lockout_end(1'b0, n);
          checks++;
          if (n != LOCKOUT_CYCLES) begin
            errors++;
            $display("FAIL rand_lock_dwell: got %0d expected %0d", n, LOCKOUT_CYCLES);
          end
          m_tries = MAX_TRIES;
        end else begin
          checks++;
          if ({bus.disp_mode, bus.tries_left} !== {3'(D_CLOSED), 3'(m_tries)}) begin
            errors++;
            $display("FAIL rand_closed: disp=%0d tries=%0d expected %0d/%0d",
                     bus.disp_mode, bus.tries_left, D_CLOSED, m_tries);
          end
          commit(4'($urandom_range(0, 9)));
        end
      end
      checks++;
      if ({bus.digit_idx, bus.tries_left, bus.is_open, bus.lockout_active}
          !== {3'd0, 3'(m_tries), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rand_ready: idx=%0d tries=%0d open=%0b lock=%0b expected 0/%0d/0/0",
                 bus.digit_idx, bus.tries_left, bus.is_open, bus.lockout_active, m_tries);
      end
    end
  endtask

  initial begin
    code[0] = 4'd7; code[1] = 4'd2; code[2] = 4'd2; code[3] = 4'd2;
    code[4] = 4'd9; code[5] = 4'd7; code[6] = 4'd0; code[7] = 4'd0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    bus.digit_in = 4'd0;
    test_reset();
    test_open();
    test_closed();
    test_lockout();
    test_error_digit();
    test_clear_commit();
    test_enter_held_reset();
    test_reset_mid_lockout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Supervisory FSM for the DE1-SoC combination lock.
- Sequences an external digit-compare datapath by stepping `digit_idx`; the datapath returns `digit_match`.
- Counts failed attempts and imposes a timed lockout after `MAX_TRIES` failures.
- Selects the display mode consumed by the HEX driver.

Parameters:
- CODE_LEN, 6: digits per combination.
- MAX_TRIES, 3: failed attempts before lockout; must be 1..7.
- LOCKOUT_CYCLES, 50000000: lockout duration in clk cycles; must be ≥ 1.
- IDX_W, $clog2(CODE_LEN): width of `digit_idx`.

Ports:
- clk  in  1  system clock (inverted KEY[0] at top level).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- enter  in  1  commit button, level; each rising edge commits one digit.
- clear  in  1  abort/relock request, level.
- digit_in  in  4  switch value being committed; values > 9 are invalid.
- digit_match  in  1  from datapath, combinational: `digit_in` == code[`digit_idx`].
- digit_idx  out  IDX_W  position currently being compared.
- disp_mode  out  3  0=DIGIT, 1=OPEN, 2=CLOSED, 3=LOCKED, 4=ERROR.
- tries_left  out  3  remaining attempts.
- is_open  out  1  high in OPEN.
- lockout_active  out  1  high in LOCKOUT.

Behaviour:
- Commit detection
  - `enter_q` is a register; `commit = enter & ~enter_q`.
  - `enter_q` resets to 1, so an enter held through reset release does not commit.
- Reset (asynchronous)
  - state=ENTRY, digit_idx=0, bad=0, tries_left=MAX_TRIES.
  - disp_mode=DIGIT, is_open=0, lockout_active=0, lockout counter=0.
- Output timing
  - All outputs are registered, Moore style.
  - Each output reflects the new state one cycle after the triggering commit/clear edge.
- ENTRY state
  - On commit, if `digit_in` > 9 or `digit_match`=0: set sticky `bad`.
  - If digit_idx < CODE_LEN-1 on commit: increment digit_idx.
  - If digit_idx = CODE_LEN-1 on commit:
    - If !bad and the final digit matches: go to OPEN.
    - Otherwise decrement tries_left. If it becomes 0, go to LOCKOUT and load the counter with LOCKOUT_CYCLES-1; else go to CLOSED.
    - In all cases clear digit_idx and bad.
  - disp_mode is ERROR while `digit_in` > 9; otherwise DIGIT.
  - Invalid digits are still committed and count as mismatches.
- CLOSED state
  - disp_mode=CLOSED.
  - Next commit returns to ENTRY with digit_idx=0. That commit does not itself enter a digit.
- OPEN state
  - disp_mode=OPEN, is_open=1.
  - Commits are ignored.
  - `clear` returns to ENTRY, tries_left=MAX_TRIES.
- LOCKOUT state
  - disp_mode=LOCKED, lockout_active=1.
  - Counter decrements every cycle; commit and clear are ignored.
  - When the counter reaches 0, the next edge goes to ENTRY with tries_left=MAX_TRIES.
  - Dwell in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- `clear` in ENTRY or CLOSED: go to ENTRY, digit_idx=0, bad=0; tries_left unchanged.
- Simultaneous clear and commit: clear wins; the commit is discarded.
- Reset mid-lockout: lockout is abandoned and tries_left is restored.
- tries_left never underflows.
- Illegal state encoding recovers to ENTRY with reset values.

Optional Feature:
- Macro: LOCK_INACTIVITY_TIMEOUT_EN.
- When defined:
  - Adds parameter INACT_CYCLES (default 250000000).
  - In ENTRY with digit_idx≠0, an idle counter counts cycles since the last commit.
  - At INACT_CYCLES the partial attempt is aborted like `clear`: digit_idx=0, bad=0, no try consumed.
  - The idle counter reloads on every commit and on entry into ENTRY.
- When undefined: no idle counter exists, and a partial entry persists indefinitely.

Decomposition:
- Package `lock_pkg`:
  - `state_t` enum {ENTRY, CLOSED, OPEN, LOCKOUT}.
  - `disp_mode_t` enum (values as above).
  - Constant MAX_DIGIT=4'd9.
- Sub-module `lockout_timer`:
  - Parameterised down-counter with ports clk, rst_n, load, done.
  - Reused for the optional inactivity counter.

Test Plan (CODE_LEN=6, MAX_TRIES=3, LOCKOUT_CYCLES=20, bench datapath code 7-2-2-2-9-7):
- Commit 7,2,2,2,9,7 → digit_idx steps 0..5; one cycle after the 6th commit is_open=1, disp_mode=OPEN; clear → ENTRY, tries_left=3.
- Commit 7,3,2,2,9,7 → CLOSED, tries_left=2; any commit → ENTRY with digit_idx=0.
- Three wrong 6-digit attempts → LOCKOUT, tries_left=0; commits and clear are ignored for exactly 20 cycles; then ENTRY, tries_left=3.
- digit_in=4'hB in ENTRY → disp_mode=ERROR without commit; committing it, then 5 correct digits → CLOSED, tries_left=2.
- Three correct digits, then clear and commit in the same cycle → digit_idx=0, tries_left=3, the commit is ignored.
- Hold enter=1 through rst_n release → no commit, digit_idx=0. Assert rst_n=0 mid-lockout → immediate ENTRY, tries_left=3, lockout_active=0 without waiting for a clock.
